// File: rtl/lsm_sequencer.sv
// lsm_sequencer: sequencer for Load/Store Multiple register transfers.
//   Decodes the register list of an LDM/STM held in IR and presents one
//   register number and Rn-relative byte offset per transfer. Registers go
//   in ascending order, with the lowest register at the lowest address.
// Ports:
//   CLK, RESET       clock; asynchronous active-low reset
//   IR               instruction: [27:25] class, [24] P, [23] U, [20] L, [15:0] list
//   LSM_START        latch IR and begin a sequence (honoured only in IDLE)
//   LSM_STEP         current transfer complete, advance (honoured only in XFER)
//   LSM_DETECT       IR is LDM/STM with a non-empty list (combinational)
//   LSM_END          current register is the last of the sequence
//   LSM_BUSY         sequence in progress
//   LSM_DONE         one-cycle pulse after the final step
//   REG_NUM          register for this transfer
//   LSM_OFS          byte offset from Rn for this transfer
//   LSM_WB_OFS       base writeback offset (+/- WORD_BYTES*count)
//   LSM_LOAD         latched L bit (1 = LDM)
module lsm_sequencer #(
  parameter int WORD_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic        LSM_START,
  input  logic        LSM_STEP,
  output logic        LSM_DETECT,
  output logic        LSM_END,
  output logic        LSM_BUSY,
  output logic        LSM_DONE,
  output logic [3:0]  REG_NUM,
  output logic [31:0] LSM_OFS,
  output logic [31:0] LSM_WB_OFS,
  output logic        LSM_LOAD
);

  localparam logic [31:0] WB = 32'(WORD_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] ofs_q, ofs_d;
  logic [31:0] wb_ofs_q, wb_ofs_d;
  logic        load_q, load_d;

  logic [4:0]  pop;
  logic [31:0] span;
  logic [3:0]  low_idx;
  logic        last;
  logic        unused_ir;

  assign unused_ir  = ^{IR[31:28], IR[22:21], IR[19:16]};
  assign LSM_DETECT = (IR[27:25] == 3'b100) && (IR[15:0] != 16'd0);

  // Register count of the incoming list and its span in bytes.
  always_comb begin
    pop = 5'd0;
    for (int i = 0; i < 16; i++) pop = pop + {4'd0, IR[i]};
  end
  assign span = {27'd0, pop} * WB;

  // Lowest set bit of the remaining mask (scan high-to-low so low wins).
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (mask_q[i]) low_idx = i[3:0];
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign last = (mask_q != 16'd0) && ((mask_q & (mask_q - 16'd1)) == 16'd0);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ofs_d    = ofs_q;
    wb_ofs_d = wb_ofs_q;
    load_d   = load_q;
    case (state_q)
      IDLE: begin
        if (LSM_START && LSM_DETECT) begin
          mask_d   = IR[15:0];
          load_d   = IR[20];
          wb_ofs_d = IR[23] ? span : (32'd0 - span);
          // Offset of the lowest register relative to Rn for each mode.
          case ({IR[24], IR[23]})
            2'b01:   ofs_d = 32'd0;           // IA
            2'b11:   ofs_d = WB;              // IB
            2'b00:   ofs_d = WB - span;       // DA
            default: ofs_d = 32'd0 - span;    // DB
          endcase
          state_d  = XFER;
        end
      end
      XFER: begin
        if (LSM_STEP) begin
          mask_d = mask_q & (mask_q - 16'd1);
          ofs_d  = ofs_q + WB;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      mask_q   <= 16'd0;
      ofs_q    <= 32'd0;
      wb_ofs_q <= 32'd0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ofs_q    <= ofs_d;
      wb_ofs_q <= wb_ofs_d;
      load_q   <= load_d;
    end
  end

  assign LSM_BUSY   = (state_q == XFER);
  assign LSM_DONE   = (state_q == DONE);
  assign LSM_END    = LSM_BUSY && last;
  assign REG_NUM    = LSM_BUSY ? low_idx : 4'd0;
  assign LSM_OFS    = LSM_BUSY ? ofs_q : 32'd0;
  assign LSM_WB_OFS = wb_ofs_q;
  assign LSM_LOAD   = load_q;

endmodule
